sp_result_collector: RTL and testbench

- Downstream consumer of the signal-processing (SP) stage.
- Captures each 3-beat SP output burst in (max, median, min) order and computes range = max - min.
- Flags ordering and protocol errors, and buffers completed records in a small FIFO for a valid/ready consumer such as the scoreboard or host interface.
- Keeps running counts of good records, truncated bursts and dropped records.

---
 rtl/sp_result_collector_pkg.sv | 22 ++
 rtl/sp_result_collector_if.sv | 25 ++
 rtl/sp_result_collector_fifo.sv | 46 ++++
 rtl/sp_result_collector.sv | 117 +++++++++++
 tb/tb_sp_result_collector.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sp_result_collector_pkg.sv
// Shared definitions for the SP result collector: widths, capture states
// and the bit layout of a packed result record.
package sp_defs;

  localparam int DATA_W  = 10;
  localparam int RANGE_W = 11;
  localparam int REC_W   = 3 * DATA_W + RANGE_W + 1;

  // Record layout, MSB first: max | med | min | range | order_err
  localparam int MAX_LSB   = 32;
  localparam int MED_LSB   = 22;
  localparam int MIN_LSB   = 12;
  localparam int RANGE_LSB = 1;
  localparam int ERR_BIT   = 0;

  typedef enum logic [1:0] {
    S_MAX = 2'd0,
    S_MED = 2'd1,
    S_MIN = 2'd2
  } state_t;

endpackage

// File: rtl/sp_result_collector_if.sv
// Burst input and record output bundle for the SP result collector.
interface sp_result_collector_if;
  import sp_defs::*;

  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_max;
  logic [DATA_W-1:0]  out_med;
  logic [DATA_W-1:0]  out_min;
  logic [RANGE_W-1:0] out_range;
  logic               out_order_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_max, out_med, out_min, out_range, out_order_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_max, out_med, out_min, out_range, out_order_err
  );

endinterface

// File: rtl/sp_result_collector_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is still accepted when
// a pop happens on the same edge.
module sp_rec_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  // The extra pointer MSB separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sp_result_collector.sv
// Captures 3-beat SP bursts (max, med, min), forms range/order records and
// queues them for a valid/ready consumer with saturating statistics.
module sp_result_collector
  import sp_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sp_result_collector_if.slave  bus,
  output logic [CNT_W-1:0]      good_cnt,
  output logic [CNT_W-1:0]      trunc_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  state_t             state;
  state_t             state_nx;
  logic [DATA_W-1:0]  max_q;
  logic [DATA_W-1:0]  med_q;
  logic               latch_max;
  logic               latch_med;
  logic               push;
  logic               trunc;
  logic [RANGE_W-1:0] range;
  logic               order_err;
  logic [REC_W-1:0]   rec_in;
  logic [REC_W-1:0]   rec_out;
  logic               full;
  logic               empty;
  logic               pop_fire;
  logic               good_inc;
  logic               drop_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_MAX;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    latch_max = 1'b0;
    latch_med = 1'b0;
    push      = 1'b0;
    trunc     = 1'b0;
    case (state)
      S_MAX: if (bus.in_valid) begin
        latch_max = 1'b1;
        state_nx  = S_MED;
      end
      S_MED: if (bus.in_valid) begin
        latch_med = 1'b1;
        state_nx  = S_MIN;
      end else begin
        trunc    = 1'b1;
        state_nx = S_MAX;
      end
      S_MIN: begin
        if (bus.in_valid) push = 1'b1;
        else              trunc = 1'b1;
        state_nx = S_MAX;
      end
      default: state_nx = S_MAX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      med_q <= '0;
    end else begin
      if (latch_max) max_q <= bus.in_data;
      if (latch_med) med_q <= bus.in_data;
    end
  end

  // Sign-extend before subtracting so the full 10-bit span fits without wrap.
  assign range     = {max_q[DATA_W-1], max_q} - {bus.in_data[DATA_W-1], bus.in_data};
  assign order_err = ($signed(max_q) < $signed(med_q)) | ($signed(med_q) < $signed(bus.in_data));
  assign rec_in    = {max_q, med_q, bus.in_data, range, order_err};

  assign pop_fire = bus.out_ready & ~empty;
  assign good_inc = push & (~full | pop_fire);
  assign drop_inc = push & full & ~pop_fire;

  sp_rec_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (bus.out_ready),
    .wdata (rec_in),
    .rdata (rec_out),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid     = ~empty;
  assign bus.out_max       = rec_out[MAX_LSB +: DATA_W];
  assign bus.out_med       = rec_out[MED_LSB +: DATA_W];
  assign bus.out_min       = rec_out[MIN_LSB +: DATA_W];
  assign bus.out_range     = rec_out[RANGE_LSB +: RANGE_W];
  assign bus.out_order_err = rec_out[ERR_BIT];

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt  <= '0;
      trunc_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (good_inc && good_cnt  != '1) good_cnt  <= good_cnt  + 1'b1;
      if (trunc    && trunc_cnt != '1) trunc_cnt <= trunc_cnt + 1'b1;
      if (drop_inc && drop_cnt  != '1) drop_cnt  <= drop_cnt  + 1'b1;
    end
  end

endmodule

// File: tb/tb_sp_result_collector.sv
// Directed self-checking bench for sp_result_collector: drives on the falling
// edge, samples on the falling edge after the capturing rising edge.
module tb_sp_result_collector;

  logic       clk;
  logic       rst_n;
  logic [7:0] good_cnt;
  logic [7:0] trunc_cnt;
  logic [7:0] drop_cnt;
  int         checks;
  int         failures;

  sp_result_collector_if ifc ();

  sp_result_collector #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .good_cnt  (good_cnt),
    .trunc_cnt (trunc_cnt),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic beat(input logic [9:0] d);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;
    #12;
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ifc.out_valid); end
    checks++; if (ifc.out_max !== 10'd0) begin failures++; $display("FAIL reset_max got=%0d exp=0", ifc.out_max); end
    checks++; if (ifc.out_range !== 11'd0) begin failures++; $display("FAIL reset_range got=%0d exp=0", ifc.out_range); end
    checks++; if ({good_cnt, trunc_cnt, drop_cnt} !== 24'd0) begin failures++; $display("FAIL reset_cnts got=%0d/%0d/%0d exp=0/0/0", good_cnt, trunc_cnt, drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single(input logic [7:0] exp_good, input string tag);
    ifc.out_ready = 1'b1;
    beat(10'sd120);
    beat(10'sd15);
    beat(-10'sd40);
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL %s_early_valid got=%0b exp=0", tag, ifc.out_valid); end
    idle();
    checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%0b exp=1", tag, ifc.out_valid); end
    checks++; if (ifc.out_max !== 10'sd120) begin failures++; $display("FAIL %s_max got=%0d exp=120", tag, $signed(ifc.out_max)); end
    checks++; if (ifc.out_med !== 10'sd15) begin failures++; $display("FAIL %s_med got=%0d exp=15", tag, $signed(ifc.out_med)); end
    checks++; if (ifc.out_min !== -10'sd40) begin failures++; $display("FAIL %s_min got=%0d exp=-40", tag, $signed(ifc.out_min)); end
    checks++; if (ifc.out_range !== 11'sd160) begin failures++; $display("FAIL %s_range got=%0d exp=160", tag, $signed(ifc.out_range)); end
    checks++; if (ifc.out_order_err !== 1'b0) begin failures++; $display("FAIL %s_err got=%0b exp=0", tag, ifc.out_order_err); end
    checks++; if (good_cnt !== exp_good) begin failures++; $display("FAIL %s_good got=%0d exp=%0d", tag, good_cnt, exp_good); end
    checks++; if (trunc_cnt !== 8'd0) begin failures++; $display("FAIL %s_trunc got=%0d exp=0", tag, trunc_cnt); end
    @(negedge clk);
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL %s_popped got=%0b exp=0", tag, ifc.out_valid); end
  endtask

  task automatic test_extreme();
    beat(10'sd511);
    beat(10'sd0);
    beat(-10'sd512);
    idle();
    checks++; if (ifc.out_range !== 11'sd1023) begin failures++; $display("FAIL extreme_range got=%0d exp=1023", $signed(ifc.out_range)); end
    checks++; if (ifc.out_min !== -10'sd512) begin failures++; $display("FAIL extreme_min got=%0d exp=-512", $signed(ifc.out_min)); end
    checks++; if (ifc.out_order_err !== 1'b0) begin failures++; $display("FAIL extreme_err got=%0b exp=0", ifc.out_order_err); end
    checks++; if (good_cnt !== 8'd2) begin failures++; $display("FAIL extreme_good got=%0d exp=2", good_cnt); end
    @(negedge clk);
  endtask

  task automatic test_order_err();
    beat(10'sd5);
    beat(10'sd9);
    beat(10'sd1);
    idle();
    checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL order_valid got=%0b exp=1", ifc.out_valid); end
    checks++; if (ifc.out_order_err !== 1'b1) begin failures++; $display("FAIL order_err got=%0b exp=1", ifc.out_order_err); end
    checks++; if (ifc.out_range !== 11'sd4) begin failures++; $display("FAIL order_range got=%0d exp=4", $signed(ifc.out_range)); end
    checks++; if (good_cnt !== 8'd3) begin failures++; $display("FAIL order_good got=%0d exp=3", good_cnt); end
    @(negedge clk);
  endtask

  task automatic test_truncated();
    beat(10'sd70);
    beat(10'sd30);
    idle();
    @(negedge clk);
    checks++; if (trunc_cnt !== 8'd1) begin failures++; $display("FAIL trunc_cnt got=%0d exp=1", trunc_cnt); end
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL trunc_valid got=%0b exp=0", ifc.out_valid); end
    beat(10'sd3);
    beat(10'sd2);
    beat(10'sd1);
    idle();
    checks++; if (ifc.out_max !== 10'sd3 || ifc.out_med !== 10'sd2 || ifc.out_min !== 10'sd1) begin failures++; $display("FAIL trunc_next_rec got=%0d,%0d,%0d exp=3,2,1", $signed(ifc.out_max), $signed(ifc.out_med), $signed(ifc.out_min)); end
    checks++; if (ifc.out_range !== 11'sd2 || ifc.out_order_err !== 1'b0) begin failures++; $display("FAIL trunc_next_arith got=%0d/%0b exp=2/0", $signed(ifc.out_range), ifc.out_order_err); end
    checks++; if (good_cnt !== 8'd4) begin failures++; $display("FAIL trunc_next_good got=%0d exp=4", good_cnt); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0] em;
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      beat(10'(100 + k));
      beat(10'(50 + k));
      beat(10'(k));
    end
    idle();
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL b2b_drop got=%0d exp=2", drop_cnt); end
    checks++; if (good_cnt !== 8'd8) begin failures++; $display("FAIL b2b_good got=%0d exp=8", good_cnt); end
    checks++; if (trunc_cnt !== 8'd1) begin failures++; $display("FAIL b2b_trunc got=%0d exp=1", trunc_cnt); end
    @(negedge clk);
    checks++; if (ifc.out_max !== 10'sd100 || ifc.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_hold got=%0d/%0b exp=100/1", $signed(ifc.out_max), ifc.out_valid); end
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      em = 10'(100 + i);
      checks++; if (ifc.out_valid !== 1'b1 || ifc.out_max !== em || ifc.out_min !== 10'(i)) begin failures++; $display("FAIL b2b_drain%0d got=%0b,%0d,%0d exp=1,%0d,%0d", i, ifc.out_valid, ifc.out_max, ifc.out_min, em, i); end
      @(negedge clk);
    end
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b exp=0", ifc.out_valid); end
  endtask

  task automatic test_full_pop();
    logic [9:0] em;
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      beat(10'(200 + k));
      beat(10'sd100);
      beat(10'(-k));
      if (k == 4) ifc.out_ready = 1'b1;
    end
    idle();
    ifc.out_ready = 1'b0;
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL fullpop_drop got=%0d exp=2", drop_cnt); end
    checks++; if (good_cnt !== 8'd13) begin failures++; $display("FAIL fullpop_good got=%0d exp=13", good_cnt); end
    ifc.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      em = 10'(200 + i);
      checks++; if (ifc.out_valid !== 1'b1 || ifc.out_max !== em || ifc.out_min !== 10'(-i)) begin failures++; $display("FAIL fullpop_drain%0d got=%0b,%0d,%0d exp=1,%0d,%0d", i, ifc.out_valid, ifc.out_max, $signed(ifc.out_min), em, -i); end
      @(negedge clk);
    end
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL fullpop_empty got=%0b exp=0", ifc.out_valid); end
  endtask

  task automatic test_async_reset();
    ifc.out_ready = 1'b0;
    beat(10'sd1);
    beat(10'sd1);
    beat(10'sd1);
    beat(10'sd7);
    beat(10'sd8);
    @(posedge clk);
    #2;
    rst_n        = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    checks++; if (ifc.out_valid !== 1'b0 || ifc.out_max !== 10'd0) begin failures++; $display("FAIL areset_out got=%0b/%0d exp=0/0", ifc.out_valid, ifc.out_max); end
    checks++; if ({good_cnt, trunc_cnt, drop_cnt} !== 24'd0) begin failures++; $display("FAIL areset_cnts got=%0d/%0d/%0d exp=0/0/0", good_cnt, trunc_cnt, drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    test_single(8'd1, "after_reset");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single(8'd1, "single");
    test_extreme();
    test_order_err();
    test_truncated();
    test_back_to_back();
    test_full_pop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
